// File: rtl/smg_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : smg_bin2bcd
// Description : Sequential 20-bit binary to 6-digit packed BCD converter using
//               shift-and-add-3 (double dabble), one bit per clock. Feeds the
//               six-digit seven-segment display path. Inputs above 999999
//               saturate the display value to 999999 and raise Over_Sig.
//
// Ports       : CLK        in   system clock, rising-edge active
//               RSTn       in   asynchronous active-low reset
//               Start_Sig  in   conversion request, sampled only when idle
//               Bin_Data   in   20-bit unsigned value, captured on accept
//               Number_Sig out  packed BCD result, [23:20] = most significant
//               Done_Sig   out  one-cycle pulse when Number_Sig is updated
//               Busy_Sig   out  high while a conversion is in progress
//               Over_Sig   out  last converted input exceeded 999999
//
// Revision    : 1.0  initial release
// ============================================================================
module smg_bin2bcd (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Start_Sig,
    input  logic [19:0] Bin_Data,
    output logic [23:0] Number_Sig,
    output logic        Done_Sig,
    output logic        Busy_Sig,
    output logic        Over_Sig
);

    localparam logic [19:0] c_MAX_DEC  = 20'd999999;
    localparam logic [4:0]  c_LAST_CNT = 5'd19;
    localparam logic [23:0] c_SAT_BCD  = 24'h999999;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt,   w_cnt_nxt;
    logic [19:0] r_bin,   w_bin_nxt;
    logic [23:0] r_acc,   w_acc_nxt;
    logic        r_ovf,   w_ovf_nxt;
    logic [23:0] w_num_nxt;
    logic        w_done_nxt;
    logic        w_busy_nxt;
    logic        w_over_nxt;

    logic [23:0] w_acc_adj;    // accumulator after add-3 correction
    logic [23:0] w_acc_shift;  // accumulator after the 1-bit shift
    logic        w_acc_carry;  // bit shifted out of the top digit

    // Add-3 correction on every BCD nibble that is 5 or more, so that the
    // following doubling carries correctly into the next decimal digit.
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        assign w_acc_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5)
                                    ? r_acc[gi*4 +: 4] + 4'd3
                                    : r_acc[gi*4 +: 4];
    end

    assign {w_acc_carry, w_acc_shift} = {w_acc_adj, r_bin[19]};

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bin_nxt   = r_bin;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_num_nxt   = Number_Sig;
        w_over_nxt  = Over_Sig;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Start_Sig) begin
                    w_state_nxt = S_SHIFT;
                    w_bin_nxt   = Bin_Data;
                    w_acc_nxt   = 24'h000000;
                    w_cnt_nxt   = 5'd0;
                    w_ovf_nxt   = (Bin_Data > c_MAX_DEC);
                end
            end
            S_SHIFT: begin
                w_acc_nxt = w_acc_shift;
                w_bin_nxt = {r_bin[18:0], 1'b0};
                w_cnt_nxt = r_cnt + 5'd1;
                // A carry out of the top digit can only happen for values of
                // 1000000 or more, which the compare already flagged; folding
                // it in keeps the flag sticky and self-consistent.
                w_ovf_nxt = r_ovf | w_acc_carry;
                if (r_cnt == c_LAST_CNT) begin
                    w_state_nxt = S_IDLE;
                    w_num_nxt   = w_ovf_nxt ? c_SAT_BCD : w_acc_shift;
                    w_over_nxt  = w_ovf_nxt;
                    w_done_nxt  = 1'b1;
                end
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_SHIFT);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_bin      <= 20'd0;
            r_acc      <= 24'h000000;
            r_ovf      <= 1'b0;
            Number_Sig <= 24'h000000;
            Done_Sig   <= 1'b0;
            Busy_Sig   <= 1'b0;
            Over_Sig   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bin      <= w_bin_nxt;
            r_acc      <= w_acc_nxt;
            r_ovf      <= w_ovf_nxt;
            Number_Sig <= w_num_nxt;
            Done_Sig   <= w_done_nxt;
            Busy_Sig   <= w_busy_nxt;
            Over_Sig   <= w_over_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smg_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_smg_bin2bcd
// Description : Self-checking scoreboard bench for smg_bin2bcd. Stimulus pushes
//               the expected {Over_Sig, Number_Sig} per accepted request; a
//               monitor pops and compares on every Done_Sig pulse and checks
//               pulse width, busy length and result hold.
// Revision    : 1.0  initial release
// ============================================================================
module tb_smg_bin2bcd;

    logic        CLK;
    logic        RSTn;
    logic        Start_Sig;
    logic [19:0] Bin_Data;
    logic [23:0] Number_Sig;
    logic        Done_Sig;
    logic        Busy_Sig;
    logic        Over_Sig;

    smg_bin2bcd dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Start_Sig  (Start_Sig),
        .Bin_Data   (Bin_Data),
        .Number_Sig (Number_Sig),
        .Done_Sig   (Done_Sig),
        .Busy_Sig   (Busy_Sig),
        .Over_Sig   (Over_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_done = 0;
    logic [24:0] exp_q[$];
    int          done_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain decimal digit split, saturating above 999999
    function automatic logic [24:0] exp_of(input int unsigned v);
        logic [23:0] r;
        r = 24'h0;
        if (v > 999999) return {1'b1, 24'h999999};
        for (int d = 0; d < 6; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {1'b0, r};
    endfunction

    // Monitor / scoreboard
    initial begin : monitor
        logic [23:0] prev_num;
        logic        prev_done;
        int          busy_run;
        logic [24:0] e;
        prev_num  = 24'h0;
        prev_done = 1'b0;
        busy_run  = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RSTn) begin
                exp_q.delete();
                prev_num  = 24'h0;
                prev_done = 1'b0;
                busy_run  = 0;
            end else begin
                if (Done_Sig) begin
                    n_done++;
                    done_cyc.push_back(cyc);
                    chk("busy_with_done", 32'(Busy_Sig), 32'd0);
                    chk("done_width", 32'(prev_done), 32'd0);
                    chk("busy_len", busy_run, 20);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=%0h required=none", Number_Sig);
                    end else begin
                        e = exp_q.pop_front();
                        chk("number", 32'(Number_Sig), 32'(e[23:0]));
                        chk("over", 32'(Over_Sig), 32'(e[24]));
                    end
                end else if (Busy_Sig) begin
                    chk("hold", 32'(Number_Sig), 32'(prev_num));
                end
                busy_run  = Busy_Sig ? busy_run + 1 : 0;
                prev_num  = Number_Sig;
                prev_done = Done_Sig;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy_Sig && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (Busy_Sig) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    // Single-cycle start; returns #1 after the accepting edge
    task automatic start_conv(input logic [19:0] v, input logic [24:0] e);
        wait_idle();
        Start_Sig = 1'b1;
        Bin_Data  = v;
        exp_q.push_back(e);
        @(posedge CLK); #1;
        Start_Sig = 1'b0;
        Bin_Data  = 20'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || Busy_Sig) && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(posedge CLK); #1;
    endtask

    initial begin : stimulus
        int n0;
        int k;
        int unsigned rv;
        RSTn      = 1'b0;
        Start_Sig = 1'b0;
        Bin_Data  = 20'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_number", 32'(Number_Sig), 32'h0);
        chk("rst_done", 32'(Done_Sig), 32'd0);
        chk("rst_busy", 32'(Busy_Sig), 32'd0);
        chk("rst_over", 32'(Over_Sig), 32'd0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // Basic values and boundaries
        start_conv(20'd0,       {1'b0, 24'h000000});
        start_conv(20'd123456,  {1'b0, 24'h123456});
        start_conv(20'd999999,  {1'b0, 24'h999999});
        start_conv(20'd1000000, {1'b1, 24'h999999});
        start_conv(20'hFFFFF,   {1'b1, 24'h999999});
        start_conv(20'd59,      {1'b0, 24'h000059});
        drain();

        // Start during a conversion is ignored
        n0 = n_done;
        start_conv(20'd4095, {1'b0, 24'h004095});
        repeat (4) @(posedge CLK);
        #1;
        Start_Sig = 1'b1;
        Bin_Data  = 20'd777;
        @(posedge CLK); #1;
        Start_Sig = 1'b0;
        drain();
        repeat (25) @(posedge CLK);
        #1;
        chk("ignored_start_dones", n_done - n0, 1);

        // Start held high: back-to-back conversions every 21 cycles
        wait_idle();
        k = done_cyc.size();
        exp_q.push_back({1'b0, 24'h000007});
        exp_q.push_back({1'b0, 24'h000010});
        exp_q.push_back({1'b0, 24'h099999});
        Start_Sig = 1'b1;
        Bin_Data  = 20'd7;
        @(posedge CLK);
        repeat (20) @(posedge CLK);
        #1;
        Bin_Data = 20'd10;
        @(posedge CLK);
        repeat (20) @(posedge CLK);
        #1;
        Bin_Data = 20'd99999;
        @(posedge CLK); #1;
        Start_Sig = 1'b0;
        drain();
        chk("held_done_count", done_cyc.size() - k, 3);
        if (done_cyc.size() - k == 3) begin
            chk("held_spacing_1", done_cyc[k+1] - done_cyc[k], 21);
            chk("held_spacing_2", done_cyc[k+2] - done_cyc[k+1], 21);
        end

        // Asynchronous reset mid-conversion
        n0 = n_done;
        start_conv(20'd654321, {1'b0, 24'h654321});
        repeat (9) @(posedge CLK);
        #3;
        RSTn = 1'b0;
        #1;
        chk("midrst_number", 32'(Number_Sig), 32'h0);
        chk("midrst_done", 32'(Done_Sig), 32'd0);
        chk("midrst_busy", 32'(Busy_Sig), 32'd0);
        chk("midrst_over", 32'(Over_Sig), 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        repeat (30) @(posedge CLK);
        #1;
        chk("midrst_no_done", n_done - n0, 0);
        start_conv(20'd654321, {1'b0, 24'h654321});
        drain();

        // Random in-range values against the decimal split reference
        for (int i = 0; i < 300; i++) begin
            rv = $urandom_range(0, 999999);
            start_conv(20'(rv), exp_of(rv));
        end
        drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
